dmem_lsu: RTL

Load/store initiator that drives the 256x8 data memory (dmem) on behalf of the processor core. It accepts one request at a time over a valid/ready handshake and sequences the dmem's registered-read, synchronous-write port. Supported operations are LOAD, STORE, atomic ADD (read-modify-write) and SWAP. Each request returns a response over a second valid/ready handshake. It sits between the core's execute stage and dmem.

---
 rtl/dmem_lsu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store initiator for the 256x8 registered-read dmem: LOAD, STORE, atomic ADD and SWAP,
// one request at a time, with a valid/ready request channel and a valid/ready response channel.
module dmem_lsu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_carry,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPT, S_WRITE, S_RESP} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_ADD, OP_SWAP} op_t;

    state_t            state, state_d;
    op_t               op_q, op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_carry_d;
    logic [DATA_W:0]   sum;

    assign req_ready = (state == S_IDLE) && reset;
    assign busy      = (state != S_IDLE);
    assign sum       = {1'b0, mem_rdata} + {1'b0, wdata_q};

    // State and all registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= OP_LOAD;
            wdata_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_carry <= 1'b0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_carry <= rsp_carry_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (req_valid)
                         state_d = (op_t'(req_op) == OP_STORE) ? S_WRITE : S_WAIT;
            S_WAIT:  state_d = S_CAPT;
            S_CAPT:  state_d = (op_q == OP_LOAD) ? S_RESP : S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        wdata_d     = wdata_q;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_carry_d = rsp_carry;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_d       = op_t'(req_op);
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr;
                    if (op_t'(req_op) == OP_STORE) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        mem_we_d = 1'b0;
                    end
                end
            end
            S_CAPT: begin
                rsp_rdata_d = mem_rdata;
                case (op_q)
                    OP_ADD: begin
                        mem_wdata_d = sum[DATA_W-1:0];
                        rsp_carry_d = sum[DATA_W];
                        mem_we_d    = 1'b1;
                    end
                    OP_SWAP: begin
                        mem_wdata_d = wdata_q;
                        rsp_carry_d = 1'b0;
                        mem_we_d    = 1'b1;
                    end
                    default: begin
                        rsp_carry_d = 1'b0;
                        rsp_valid_d = 1'b1;
                    end
                endcase
            end
            S_WRITE: begin
                mem_we_d    = 1'b0;
                rsp_valid_d = 1'b1;
                if (op_q == OP_STORE) begin
                    rsp_rdata_d = '0;
                    rsp_carry_d = 1'b0;
                end
            end
            S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

endmodule
